// File: rtl/bit_counter4_if.sv
// Control and status bundle for the bit_counter4 modulo up-counter.
// master drives the controls and observes the count; slave is the counter.
interface bit_counter4_if;
  logic       clr;
  logic       ld;
  logic       en;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       ovf;

  modport master (output clr, ld, en, d, input q, tc, ovf);
  modport slave  (input clr, ld, en, d, output q, tc, ovf);
endinterface

// File: rtl/bit_counter4.sv
// bit_counter4: 4-bit modulo-MOD up-counter register stage wrapped around the
// bit_inc4 incrementer. Priority per edge: clr > ld > en > hold.
// Optional macro BIT_COUNTER4_SAT_EN: saturate at MOD-1 instead of wrapping.

// 4-bit incrementer; the carry-out is not needed by the counter.
module bit_inc4 (
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = a + 4'd1;
endmodule

module bit_counter4 #(
  parameter int MOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  bit_counter4_if.slave bus
);

  if (MOD < 2 || MOD > 16) begin : g_mod_check
    $error("bit_counter4: MOD must be in 2..16");
  end

  localparam logic [3:0] LAST = 4'(MOD - 1);
  localparam logic [4:0] MOD5 = 5'(MOD);

  logic [3:0] q_r;
  logic [3:0] q_next;
  logic [3:0] inc_q;
  logic       ovf_r;
  logic       ovf_next;
  logic       at_last;

  bit_inc4 u_inc (
    .a (q_r),
    .y (inc_q)
  );

  assign at_last = (q_r == LAST);
  assign bus.q   = q_r;
  assign bus.ovf = ovf_r;
  assign bus.tc  = bus.en & ~bus.clr & ~bus.ld & at_last;

  // Next-state mux: clear, clamped load, increment/wrap (or saturate), hold.
  always_comb begin
    q_next   = q_r;
    ovf_next = ovf_r;
    if (bus.clr) begin
      q_next   = 4'd0;
      ovf_next = 1'b0;
    end else if (bus.ld) begin
      q_next = ({1'b0, bus.d} >= MOD5) ? LAST : bus.d;
    end else if (bus.en) begin
      if (at_last) begin
        ovf_next = 1'b1;
`ifdef BIT_COUNTER4_SAT_EN
        q_next   = q_r;
`else
        // With MOD=16 the incrementer rolls 15 over to 0 on its own.
        q_next   = (MOD == 16) ? inc_q : 4'd0;
`endif
      end else begin
        q_next = inc_q;
      end
    end
  end

  // Count and sticky overflow registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= 4'd0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      ovf_r <= ovf_next;
    end
  end

endmodule

// File: tb/tb_bit_counter4.sv
// Self-checking bench for bit_counter4: one MOD=16 and one MOD=10 instance.
// Table vectors plus model-driven sequences feed a scoreboard of expected
// q/ovf values that is popped after each rising edge.
module tb_bit_counter4;

`ifdef BIT_COUNTER4_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       clr;
    logic       ld;
    logic       en;
    logic [3:0] d;
    logic [3:0] q;
    logic       ovf;
    logic       tc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bit_counter4_if b16 ();
  bit_counter4_if b10 ();

  bit_counter4 #(.MOD(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  bit_counter4 #(.MOD(10)) dut10 (.clk(clk), .rst(rst), .bus(b10));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  exp_t sb16[$];
  exp_t sb10[$];

  logic [3:0] m16_q = 4'd0;
  logic       m16_o = 1'b0;
  logic [3:0] m10_q = 4'd0;
  logic       m10_o = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int mod, input logic c, input logic l, input logic e,
                       input logic [3:0] dd, inout logic [3:0] mq, inout logic mo,
                       output logic mt);
    mt = e & ~c & ~l & (int'(mq) == mod - 1);
    if (c) begin
      mq = 4'd0;
      mo = 1'b0;
    end else if (l) begin
      mq = (int'(dd) >= mod) ? 4'(mod - 1) : dd;
    end else if (e) begin
      if (int'(mq) == mod - 1) begin
        mo = 1'b1;
        if (!SAT) mq = 4'd0;
      end else begin
        mq = mq + 4'd1;
      end
    end
  endtask

  // Called just after a falling edge: drive, check tc, push expectation,
  // cross the rising edge, pop and compare, return at the next falling edge.
  task automatic step(input bit is10, input logic c, input logic l, input logic e,
                      input logic [3:0] dd, input bit use_rec, input vec_t rec);
    logic mt;
    exp_t ex;
    exp_t got;
    if (is10) begin
      b10.clr = c; b10.ld = l; b10.en = e; b10.d = dd;
    end else begin
      b16.clr = c; b16.ld = l; b16.en = e; b16.d = dd;
    end
    #1;
    if (is10) begin
      model(10, c, l, e, dd, m10_q, m10_o, mt);
      if (use_rec) begin
        check("tc10_vec", b10.tc, rec.tc);
        ex.q = rec.q; ex.ovf = rec.ovf;
      end else begin
        check("tc10", b10.tc, mt);
        ex.q = m10_q; ex.ovf = m10_o;
      end
      sb10.push_back(ex);
    end else begin
      model(16, c, l, e, dd, m16_q, m16_o, mt);
      check("tc16", b16.tc, mt);
      ex.q = m16_q; ex.ovf = m16_o;
      sb16.push_back(ex);
    end
    @(posedge clk);
    #1;
    if (is10) begin
      if (sb10.size() == 0) begin
        check("sb10_empty", 8'd1, 8'd0);
      end else begin
        got = sb10.pop_front();
        check("q10", b10.q, got.q);
        check("ovf10", b10.ovf, got.ovf);
      end
    end else begin
      if (sb16.size() == 0) begin
        check("sb16_empty", 8'd1, 8'd0);
      end else begin
        got = sb16.pop_front();
        check("q16", b16.q, got.q);
        check("ovf16", b16.ovf, got.ovf);
      end
    end
    @(negedge clk);
  endtask

  vec_t vecs[10];
  vec_t none;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    none = '{clr: 1'b0, ld: 1'b0, en: 1'b0, d: 4'd0, q: 4'd0, ovf: 1'b0, tc: 1'b0};
    // dut10 vectors from reset: {clr, ld, en, d, q after edge, ovf after edge, tc before edge}
    vecs[0] = '{clr: 1'b0, ld: 1'b1, en: 1'b0, d: 4'd4,  q: 4'd4, ovf: 1'b0, tc: 1'b0};
    vecs[1] = '{clr: 1'b0, ld: 1'b0, en: 1'b1, d: 4'd0,  q: 4'd5, ovf: 1'b0, tc: 1'b0};
    vecs[2] = '{clr: 1'b0, ld: 1'b1, en: 1'b0, d: 4'd13, q: 4'd9, ovf: 1'b0, tc: 1'b0};
    vecs[3] = '{clr: 1'b0, ld: 1'b0, en: 1'b0, d: 4'd2,  q: 4'd9, ovf: 1'b0, tc: 1'b0};
    vecs[4] = '{clr: 1'b0, ld: 1'b1, en: 1'b1, d: 4'd3,  q: 4'd3, ovf: 1'b0, tc: 1'b0};
    vecs[5] = '{clr: 1'b0, ld: 1'b1, en: 1'b0, d: 4'd10, q: 4'd9, ovf: 1'b0, tc: 1'b0};
    vecs[6] = '{clr: 1'b1, ld: 1'b1, en: 1'b1, d: 4'd5,  q: 4'd0, ovf: 1'b0, tc: 1'b0};
    vecs[7] = '{clr: 1'b0, ld: 1'b0, en: 1'b1, d: 4'd0,  q: 4'd1, ovf: 1'b0, tc: 1'b0};
    vecs[8] = '{clr: 1'b0, ld: 1'b1, en: 1'b0, d: 4'd15, q: 4'd9, ovf: 1'b0, tc: 1'b0};
    vecs[9] = '{clr: 1'b1, ld: 1'b0, en: 1'b0, d: 4'd0,  q: 4'd0, ovf: 1'b0, tc: 1'b0};

    b16.clr = 1'b0; b16.ld = 1'b0; b16.en = 1'b0; b16.d = 4'd0;
    b10.clr = 1'b0; b10.ld = 1'b0; b10.en = 1'b0; b10.d = 4'd0;

    rst = 1'b1;
    #2;
    check("rst_q16", b16.q, 4'd0);
    check("rst_ovf16", b16.ovf, 1'b0);
    check("rst_tc16", b16.tc, 1'b0);
    check("rst_q10", b10.q, 4'd0);
    check("rst_ovf10", b10.ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // dut10 table
    for (int i = 0; i < 10; i++)
      step(1'b1, vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].d, 1'b1, vecs[i]);

    // dut10 wrap (or saturation) then loads keep ovf
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, none);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 1'b0, none);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);

    // dut16 reset mid-count
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);
    check("q16_before_rst", b16.q, 4'd7);
    b16.en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_async_q16", b16.q, 4'd0);
    check("rst_async_ovf16", b16.ovf, 1'b0);
    #1 rst = 1'b0;
    m16_q = 4'd0;
    m16_o = 1'b0;
    m10_q = 4'd0;
    m10_o = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);

    // dut16 full wrap from 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, none);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);

    // ld beats en at 15
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, none);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, none);

    // hold at 6
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, none);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, none);

    // clr beats ld
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, none);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, none);

    check("sb16_drained", 8'(sb16.size()), 8'd0);
    check("sb10_drained", 8'(sb10.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
